// File: rtl/cla_wide_add_scheduler.sv
// rtl/cla_wide_add_scheduler.sv - shared 16-bit CLA running word-serial wide additions for two requesters
// Round-robin grant in IDLE, one 16-bit word per RUN cycle (LSW first), result held in DONE until taken.

module carry_look_ahead_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
  end

  // Second level: group carries directly from group generate/propagate terms.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  always_comb begin
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

module cla_wide_add_scheduler #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [16*WORDS-1:0] req0_a,
  input  logic [16*WORDS-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [16*WORDS-1:0] req1_a,
  input  logic [16*WORDS-1:0] req1_b,
  input  logic                req1_cin,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [16*WORDS-1:0] res_sum,
  output logic                res_cout,
  output logic                res_id,
  output logic                busy
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg, last_grant, grant, accept, last_word;
  logic [IW-1:0]   idx;
  logic [15:0]     a_word, b_word, word_sum;
  logic            word_cout;

  // Ties go to whoever did not win last time; a lone valid always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = rst_n && (state == IDLE) && !grant && req0_valid;
  assign req1_ready = rst_n && (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready | req1_ready;
  assign last_word  = (idx == IW'(WORDS - 1));
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == IW'(k)) begin
        a_word = a_reg[16*k +: 16];
        b_word = b_reg[16*k +: 16];
      end
    end
  end

  carry_look_ahead_adder_16bit u_cla (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_reg),
    .sum  (word_sum),
    .cout (word_cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last_word) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry_reg  <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg      <= grant ? req1_a   : req0_a;
          b_reg      <= grant ? req1_b   : req0_b;
          carry_reg  <= grant ? req1_cin : req0_cin;
          res_id     <= grant;
          last_grant <= grant;
          idx        <= '0;
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++)
            if (idx == IW'(k)) res_sum[16*k +: 16] <= word_sum;
          carry_reg <= word_cout;
          idx       <= idx + IW'(1);
          if (last_word) res_cout <= word_cout;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_wide_add_scheduler.sv
// tb/tb_cla_wide_add_scheduler.sv - directed self-checking bench for cla_wide_add_scheduler (WORDS=4)

module tb_cla_wide_add_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [63:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_id, busy;
  logic [63:0] res_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_wide_add_scheduler #(.WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      check({tag, "_rdy_run"}, {62'd0, req1_ready, req0_ready}, 64'd0);
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    check("hs_valid_drop", res_valid, 0);
    check("hs_idle", busy, 0);
  endtask

  task automatic run_op(input string tag, input logic id, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [63:0] exp_sum, input logic exp_cout);
    int n;
    int lat;
    if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    check({tag, "_accept"}, (n < 20), 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_result(tag, lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, res_sum, exp_sum);
    check({tag, "_cout"}, res_cout, exp_cout);
    check({tag, "_id"}, res_id, id);
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    logic [2:0] order;
    logic seen;

    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;

    // T1: reset state
    tick(); tick();
    check("t1_valid", res_valid, 0);
    check("t1_sum", res_sum, 0);
    check("t1_cout", res_cout, 0);
    check("t1_id", res_id, 0);
    check("t1_busy", busy, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t1_rdy_in_reset", {62'd0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold_busy", busy, 0);
      check("t1_hold_valid", res_valid, 0);
    end

    // T2 / T3: single requesters
    run_op("t2", 1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0001_0000_0000_0000, 1'b0);
    run_op("t3", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1);

    // T4: both held for three operations, expect grant order 0,1,0
    order = 3'b010;
    req0_a = 64'd5; req0_b = 64'd7; req0_cin = 1'b1;
    req1_a = 64'h1234_5678_9ABC_DEF0; req1_b = 64'h0FED_CBA9_8765_4321; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int op = 0; op < 3; op++) begin
      #1;
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin tick(); n++; end
      check("t4_both_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
      check("t4_grant", req1_ready, order[op]);
      tick();
      if (op == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      wait_result("t4", lat);
      check("t4_latency", lat, 4);
      check("t4_id", res_id, order[op]);
      check("t4_sum", res_sum, order[op] ? 64'h2222_2222_2222_2211 : 64'd13);
      check("t4_cout", res_cout, 0);
      handshake();
    end

    // T5: stall in DONE
    req0_a = 64'd3; req0_b = 64'd4; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    check("t5_accept", (n < 20), 1);
    tick();
    req0_valid = 1'b0;
    wait_result("t5", lat);
    req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t5_valid", res_valid, 1);
      check("t5_sum", res_sum, 64'd7);
      check("t5_cout", res_cout, 0);
      check("t5_id", res_id, 0);
      check("t5_busy", busy, 1);
      check("t5_rdy", {62'd0, req1_ready, req0_ready}, 64'd0);
      tick();
    end
    req1_valid = 1'b0;
    handshake();
    check("t5_sum_kept", res_sum, 64'd7);

    // T6: reset during RUN word 2
    req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd0; req0_cin = 1'b1; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    check("t6_accept", (n < 20), 1);
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    check("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_sum", res_sum, 0);
    check("t6_cout", res_cout, 0);
    check("t6_id", res_id, 0);
    check("t6_busy", busy, 0);
    check("t6_valid", res_valid, 0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    check("t6_no_result", seen, 0);
    run_op("t6_post", 1'b0, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
